// File: rtl/direction_pkg.sv
// Types and constants shared by the direction/PID path and the H-bridge PWM drivers.
package direction_pkg;

   typedef logic [20:0] speed_t;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DEAD
   } drv_state_t;

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Command bundle from the PID/direction path (master) to one wheel's PWM driver (slave).
interface motor_pwm_driver_if;
   import direction_pkg::*;

   logic   enable;
   logic   dir;
   speed_t speed;

   modport master (output enable, output dir, output speed);
   modport slave  (input  enable, input  dir, input  speed);

endinterface

// File: rtl/pwm_counter.sv
// Free-running modulo-PERIOD counter with synchronous clear; wrap_o marks the last count.
module pwm_counter
   import direction_pkg::*;
#(
   parameter int unsigned PERIOD = 50000
) (
   input  logic   clk,
   input  logic   clr_i,
   input  logic   en_i,
   output speed_t cnt_o,
   output logic   wrap_o
);

   speed_t cnt_q;
   speed_t cnt_d;

   assign wrap_o = en_i && (cnt_q == speed_t'(PERIOD - 1));
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || wrap_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/motor_pwm_driver.sv
// One-wheel H-bridge PWM driver: period-synchronous duty/direction update with
// enforced dead time on every reversal while running.
module motor_pwm_driver
   import direction_pkg::*;
#(
   parameter int unsigned PWM_PERIOD = 50000,
   parameter int unsigned DEAD_TIME  = 5000
) (
   input  logic                clk,
   input  logic                reset_n,
   motor_pwm_driver_if.slave   cmd,
   output logic                in1,
   output logic                in2,
   output logic                period_tick,
   output logic                dead_active
);

   drv_state_t state_q;
   speed_t     duty_q;
   logic       dir_q;
   speed_t     pend_duty_q;
   logic       pend_dir_q;
   logic       in1_q, in2_q, tick_q, dead_q;

   speed_t     pwm_cnt;
   speed_t     dead_cnt;
   logic       pwm_wrap, dead_wrap;
   logic       run_clr, dead_clr;
   speed_t     shadow_duty_d;
   logic       pwm_d;
   logic       unused_dead_cnt;

   function automatic speed_t clamp_duty(input speed_t s);
      return (s >= speed_t'(PWM_PERIOD)) ? speed_t'(PWM_PERIOD) : s;
   endfunction

   assign shadow_duty_d   = clamp_duty(cmd.speed);
   assign pwm_d           = (pwm_cnt < duty_q);
   assign run_clr         = !reset_n || !cmd.enable || (state_q != RUN);
   assign dead_clr        = !reset_n || !cmd.enable || (state_q != DEAD);
   assign unused_dead_cnt = ^dead_cnt;

   pwm_counter #(.PERIOD(PWM_PERIOD)) u_period_cnt (
      .clk    (clk),
      .clr_i  (run_clr),
      .en_i   (state_q == RUN),
      .cnt_o  (pwm_cnt),
      .wrap_o (pwm_wrap)
   );

   pwm_counter #(.PERIOD(DEAD_TIME)) u_dead_cnt (
      .clk    (clk),
      .clr_i  (dead_clr),
      .en_i   (state_q == DEAD),
      .cnt_o  (dead_cnt),
      .wrap_o (dead_wrap)
   );

   // Outputs are one cycle behind the state/counter they describe; disable forces coast.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         duty_q  <= '0;
         dir_q   <= DIR_FWD;
         in1_q   <= 1'b0;
         in2_q   <= 1'b0;
         tick_q  <= 1'b0;
         dead_q  <= 1'b0;
      end else if (!cmd.enable) begin
         state_q <= IDLE;
         in1_q   <= 1'b0;
         in2_q   <= 1'b0;
         tick_q  <= 1'b0;
         dead_q  <= 1'b0;
      end else begin
         in1_q  <= (state_q == RUN) && pwm_d && dir_q;
         in2_q  <= (state_q == RUN) && pwm_d && !dir_q;
         tick_q <= pwm_wrap;
         dead_q <= (state_q == DEAD);
         case (state_q)
            IDLE: begin
               // Bridge is already coasting, so a new direction needs no dead time.
               duty_q  <= shadow_duty_d;
               dir_q   <= cmd.dir;
               state_q <= RUN;
            end
            RUN: begin
               if (pwm_wrap) begin
                  if (cmd.dir == dir_q) begin
                     duty_q <= shadow_duty_d;
                  end else begin
                     pend_duty_q <= shadow_duty_d;
                     pend_dir_q  <= cmd.dir;
                     state_q     <= DEAD;
                  end
               end
            end
            DEAD: begin
               if (dead_wrap) begin
                  duty_q  <= pend_duty_q;
                  dir_q   <= pend_dir_q;
                  state_q <= RUN;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in1         = in1_q;
   assign in2         = in2_q;
   assign period_tick = tick_q;
   assign dead_active = dead_q;

endmodule
